// File: rtl/redmule_tile_sequencer_if.sv
// Tile command channel from the sequencer to the streamer/scheduler.
// master: drives a valid command plus the tile payload and receives ready.
// slave : receives the command and returns ready.
// Payload: tile indices (m, k, n), effective sizes (rows, cols, depth),
//          and accumulate/store flags (first_n, last_n, last).
interface redmule_tile_sequencer_if;
    logic        tile_valid_o;
    logic        tile_ready_i;
    logic [15:0] tile_m_o;
    logic [15:0] tile_k_o;
    logic [15:0] tile_n_o;
    logic [7:0]  tile_rows_o;
    logic [7:0]  tile_cols_o;
    logic [7:0]  tile_depth_o;
    logic        first_n_o;
    logic        last_n_o;
    logic        last_o;

    modport master (
        output tile_valid_o,
        output tile_m_o,
        output tile_k_o,
        output tile_n_o,
        output tile_rows_o,
        output tile_cols_o,
        output tile_depth_o,
        output first_n_o,
        output last_n_o,
        output last_o,
        input  tile_ready_i
    );

    modport slave (
        input  tile_valid_o,
        input  tile_m_o,
        input  tile_k_o,
        input  tile_n_o,
        input  tile_rows_o,
        input  tile_cols_o,
        input  tile_depth_o,
        input  first_n_o,
        input  last_n_o,
        input  last_o,
        output tile_ready_i
    );
endinterface

// File: rtl/redmule_tile_sequencer.sv
// Tile-iteration sequencer for the RedMulE GEMM engine.
// Latches the tiler's iteration counts/leftovers on start_i, then walks the
// tile loops (M outer, K middle, N inner), issuing one command per tile over
// the tile_if valid/ready channel.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   clear_i                synchronous abort back to IDLE (no done pulse)
//   start_i                tiler configuration-valid pulse
//   *_iter_i, *_lftovr_i   tile counts and last-tile leftovers (0 = full)
//   tile_if                command channel (master side)
//   busy_o, done_o         job in progress / one-cycle completion pulse
//   store_cnt_o            store-triggering tiles accepted in this job
module redmule_tile_sequencer #(
    parameter int unsigned ARRAY_WIDTH = 12,
    parameter int unsigned TILE        = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [15:0]                     x_rows_iter_i,
    input  logic [15:0]                     w_cols_iter_i,
    input  logic [15:0]                     x_cols_iter_i,
    input  logic [7:0]                      x_rows_lftovr_i,
    input  logic [7:0]                      w_cols_lftovr_i,
    input  logic [7:0]                      x_cols_lftovr_i,
    redmule_tile_sequencer_if.master        tile_if,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [15:0]                     store_cnt_o
);

    localparam int unsigned IDX_W = 16;
    localparam int unsigned SZ_W  = 8;

    localparam logic [SZ_W-1:0] FULL_ROWS = SZ_W'(ARRAY_WIDTH);
    localparam logic [SZ_W-1:0] FULL_TILE = SZ_W'(TILE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched job configuration
    logic [IDX_W-1:0] m_iter_q, m_iter_d;
    logic [IDX_W-1:0] k_iter_q, k_iter_d;
    logic [IDX_W-1:0] n_iter_q, n_iter_d;
    logic [SZ_W-1:0]  m_lo_q, m_lo_d;
    logic [SZ_W-1:0]  k_lo_q, k_lo_d;
    logic [SZ_W-1:0]  n_lo_q, n_lo_d;

    // Loop indices and store counter
    logic [IDX_W-1:0] m_q, m_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] store_cnt_q, store_cnt_d;

    // Registered command payload and status
    logic             valid_q, valid_d;
    logic [SZ_W-1:0]  rows_q, rows_d;
    logic [SZ_W-1:0]  cols_q, cols_d;
    logic [SZ_W-1:0]  depth_q, depth_d;
    logic             first_n_q, first_n_d;
    logic             last_n_q, last_n_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             hs_c;
    logic             k_wrap_c;
    logic             run_d_c;
    logic             m_is_last_c;
    logic             k_is_last_c;
    logic             n_is_last_c;

    // Picks the leftover on the last index of a dimension, else the full size
    function automatic logic [SZ_W-1:0] eff_size(
        input logic            is_last,
        input logic [SZ_W-1:0] lftovr,
        input logic [SZ_W-1:0] full
    );
        return (is_last && (lftovr != '0)) ? lftovr : full;
    endfunction

    // Next-state, counter advance and next payload
    always_comb begin
        state_d     = state_q;
        m_iter_d    = m_iter_q;
        k_iter_d    = k_iter_q;
        n_iter_d    = n_iter_q;
        m_lo_d      = m_lo_q;
        k_lo_d      = k_lo_q;
        n_lo_d      = n_lo_q;
        m_d         = m_q;
        k_d         = k_q;
        n_d         = n_q;
        store_cnt_d = store_cnt_q;

        hs_c     = valid_q && tile_if.tile_ready_i;
        k_wrap_c = (k_q == IDX_W'(k_iter_q - IDX_W'(1)));

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    m_iter_d    = x_rows_iter_i;
                    k_iter_d    = w_cols_iter_i;
                    n_iter_d    = x_cols_iter_i;
                    m_lo_d      = x_rows_lftovr_i;
                    k_lo_d      = w_cols_lftovr_i;
                    n_lo_d      = x_cols_lftovr_i;
                    m_d         = '0;
                    k_d         = '0;
                    n_d         = '0;
                    store_cnt_d = '0;
                    if ((x_rows_iter_i == '0) || (w_cols_iter_i == '0) ||
                        (x_cols_iter_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (hs_c) begin
                    if (last_n_q) begin
                        store_cnt_d = IDX_W'(store_cnt_q + IDX_W'(1));
                    end
                    if (last_q) begin
                        // Park indices at zero rather than stepping past the bound
                        m_d     = '0;
                        k_d     = '0;
                        n_d     = '0;
                        state_d = DONE;
                    end else if (last_n_q) begin
                        n_d = '0;
                        if (k_wrap_c) begin
                            k_d = '0;
                            m_d = IDX_W'(m_q + IDX_W'(1));
                        end else begin
                            k_d = IDX_W'(k_q + IDX_W'(1));
                        end
                    end else begin
                        n_d = IDX_W'(n_q + IDX_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over start and over an in-flight handshake
        if (clear_i) begin
            state_d     = IDLE;
            m_iter_d    = '0;
            k_iter_d    = '0;
            n_iter_d    = '0;
            m_lo_d      = '0;
            k_lo_d      = '0;
            n_lo_d      = '0;
            m_d         = '0;
            k_d         = '0;
            n_d         = '0;
            store_cnt_d = '0;
        end

        // Payload for the tile that will be presented next cycle
        run_d_c     = (state_d == RUN);
        m_is_last_c = (m_d == IDX_W'(m_iter_d - IDX_W'(1)));
        k_is_last_c = (k_d == IDX_W'(k_iter_d - IDX_W'(1)));
        n_is_last_c = (n_d == IDX_W'(n_iter_d - IDX_W'(1)));

        valid_d   = run_d_c;
        rows_d    = run_d_c ? eff_size(m_is_last_c, m_lo_d, FULL_ROWS) : '0;
        cols_d    = run_d_c ? eff_size(k_is_last_c, k_lo_d, FULL_TILE) : '0;
        depth_d   = run_d_c ? eff_size(n_is_last_c, n_lo_d, FULL_TILE) : '0;
        first_n_d = run_d_c && (n_d == '0);
        last_n_d  = run_d_c && n_is_last_c;
        last_d    = run_d_c && m_is_last_c && k_is_last_c && n_is_last_c;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State, configuration, counters and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            m_iter_q    <= '0;
            k_iter_q    <= '0;
            n_iter_q    <= '0;
            m_lo_q      <= '0;
            k_lo_q      <= '0;
            n_lo_q      <= '0;
            m_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            store_cnt_q <= '0;
            valid_q     <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            depth_q     <= '0;
            first_n_q   <= 1'b0;
            last_n_q    <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_iter_q    <= m_iter_d;
            k_iter_q    <= k_iter_d;
            n_iter_q    <= n_iter_d;
            m_lo_q      <= m_lo_d;
            k_lo_q      <= k_lo_d;
            n_lo_q      <= n_lo_d;
            m_q         <= m_d;
            k_q         <= k_d;
            n_q         <= n_d;
            store_cnt_q <= store_cnt_d;
            valid_q     <= valid_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            depth_q     <= depth_d;
            first_n_q   <= first_n_d;
            last_n_q    <= last_n_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tile_if.tile_valid_o = valid_q;
    assign tile_if.tile_m_o     = m_q;
    assign tile_if.tile_k_o     = k_q;
    assign tile_if.tile_n_o     = n_q;
    assign tile_if.tile_rows_o  = rows_q;
    assign tile_if.tile_cols_o  = cols_q;
    assign tile_if.tile_depth_o = depth_q;
    assign tile_if.first_n_o    = first_n_q;
    assign tile_if.last_n_o     = last_n_q;
    assign tile_if.last_o       = last_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign store_cnt_o          = store_cnt_q;

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Bench for redmule_tile_sequencer: a job-level model expands each accepted
// start into the expected tile list; a negedge monitor checks every presented
// tile and completion pulse against it, and directed steps pin timing.
module tb_redmule_tile_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned TL = 16;

    typedef struct {
        logic [15:0] m;
        logic [15:0] k;
        logic [15:0] n;
        logic [7:0]  rows;
        logic [7:0]  cols;
        logic [7:0]  depth;
        logic        first_n;
        logic        last_n;
        logic        last;
    } tile_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] xr = '0;
    logic [15:0] wc = '0;
    logic [15:0] xc = '0;
    logic [7:0]  lr = '0;
    logic [7:0]  lc = '0;
    logic [7:0]  ld = '0;
    logic        busy;
    logic        done;
    logic [15:0] store_cnt;

    redmule_tile_sequencer_if tif ();

    redmule_tile_sequencer #(
        .ARRAY_WIDTH(AW),
        .TILE       (TL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .start_i        (start),
        .x_rows_iter_i  (xr),
        .w_cols_iter_i  (wc),
        .x_cols_iter_i  (xc),
        .x_rows_lftovr_i(lr),
        .w_cols_lftovr_i(lc),
        .x_cols_lftovr_i(ld),
        .tile_if        (tif.master),
        .busy_o         (busy),
        .done_o         (done),
        .store_cnt_o    (store_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model / monitor state (written only by the monitor)
    tile_t exp_q[$];
    tile_t dut_log[$];
    int    model_store = 0;
    int    job_hs = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    start_cyc = -1;
    int    first_hs_cyc = -1;
    int    last_hs_cyc = -1;
    int    stall_cnt = 0;
    bit    valid_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expand a job into its tile list straight from the loop-order rules
    task automatic build_job(input int mi, input int ki, input int ni,
                             input int r, input int c, input int d);
        tile_t t;
        exp_q.delete();
        if (mi == 0 || ki == 0 || ni == 0) return;
        for (int a = 0; a < mi; a++)
            for (int b = 0; b < ki; b++)
                for (int e = 0; e < ni; e++) begin
                    t.m       = 16'(a);
                    t.k       = 16'(b);
                    t.n       = 16'(e);
                    t.rows    = (a == mi - 1 && r != 0) ? 8'(r) : 8'(AW);
                    t.cols    = (b == ki - 1 && c != 0) ? 8'(c) : 8'(TL);
                    t.depth   = (e == ni - 1 && d != 0) ? 8'(d) : 8'(TL);
                    t.first_n = (e == 0);
                    t.last_n  = (e == ni - 1);
                    t.last    = (a == mi - 1) && (b == ki - 1) && (e == ni - 1);
                    exp_q.push_back(t);
                end
    endtask

    // Per-cycle monitor
    always @(negedge clk) begin
        if (rst_n) begin
            tile_t e;
            tile_t cur;
            if (tif.tile_valid_o) begin
                valid_seen = 1;
                if (!tif.tile_ready_i) stall_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_tile", 1, 0);
                end else begin
                    e = exp_q[0];
                    cur.m = tif.tile_m_o; cur.k = tif.tile_k_o; cur.n = tif.tile_n_o;
                    cur.rows = tif.tile_rows_o; cur.cols = tif.tile_cols_o;
                    cur.depth = tif.tile_depth_o; cur.first_n = tif.first_n_o;
                    cur.last_n = tif.last_n_o; cur.last = tif.last_o;
                    chk("tile_m", 32'(cur.m), 32'(e.m));
                    chk("tile_k", 32'(cur.k), 32'(e.k));
                    chk("tile_n", 32'(cur.n), 32'(e.n));
                    chk("tile_rows", 32'(cur.rows), 32'(e.rows));
                    chk("tile_cols", 32'(cur.cols), 32'(e.cols));
                    chk("tile_depth", 32'(cur.depth), 32'(e.depth));
                    chk("first_n", 32'(cur.first_n), 32'(e.first_n));
                    chk("last_n", 32'(cur.last_n), 32'(e.last_n));
                    chk("last", 32'(cur.last), 32'(e.last));
                    chk("busy_in_run", 32'(busy), 1);
                    chk("store_cnt_run", 32'(store_cnt), 32'(model_store));
                    if (tif.tile_ready_i && !clear) begin
                        dut_log.push_back(cur);
                        if (e.last_n) model_store++;
                        void'(exp_q.pop_front());
                        job_hs++;
                        if (job_hs == 1) first_hs_cyc = cyc;
                        last_hs_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_queue_empty", 32'(exp_q.size()), 0);
                chk("done_valid_low", 32'(tif.tile_valid_o), 0);
                chk("done_busy", 32'(busy), 1);
                chk("done_store_cnt", 32'(store_cnt), 32'(model_store));
            end
            if (clear) begin
                exp_q.delete();
                model_store = 0;
            end else if (start && !busy) begin
                build_job(int'(xr), int'(wc), int'(xc), int'(lr), int'(lc), int'(ld));
                dut_log.delete();
                model_store = 0;
                job_hs = 0;
                valid_seen = 0;
                stall_cnt = 0;
                start_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int mi, input int ki, input int ni,
                            input int r, input int c, input int d);
        xr = 16'(mi); wc = 16'(ki); xc = 16'(ni);
        lr = 8'(r);   lc = 8'(c);   ld = 8'(d);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns at the negedge where done_o is seen, or flags a timeout
    task automatic wait_done(input int budget);
        int base;
        bit seen;
        base = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        tif.tile_ready_i = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(tif.tile_valid_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_store_cnt", 32'(store_cnt), 0);
        chk("rst_rows", 32'(tif.tile_rows_o), 0);
        chk("rst_first_n", 32'(tif.first_n_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Basic loop order, ready tied high
        tif.tile_ready_i = 1'b1;
        do_start(2, 2, 3, 0, 0, 0);
        wait_done(40);
        chk("basic_hs_count", 32'(job_hs), 12);
        chk("basic_first_latency", 32'(first_hs_cyc), 32'(start_cyc + 1));
        chk("basic_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 11);
        chk("basic_done_latency", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("basic_store_at_done", 32'(store_cnt), 4);
        if (dut_log.size() == 12) begin
            chk("basic_t3_k", 32'(dut_log[3].k), 1);
            chk("basic_t3_n", 32'(dut_log[3].n), 0);
            chk("basic_t11_m", 32'(dut_log[11].m), 1);
            chk("basic_t11_n", 32'(dut_log[11].n), 2);
            for (int i = 0; i < 12; i++)
                chk("basic_last_n_pattern", 32'(dut_log[i].last_n), 32'((i % 3) == 2));
        end else begin
            chk("basic_log_size", 32'(dut_log.size()), 12);
        end
        @(negedge clk);
        chk("basic_done_one_cycle", 32'(done), 0);
        chk("basic_busy_after", 32'(busy), 0);
        tick();

        // Leftovers
        do_start(1, 2, 2, 5, 7, 3);
        wait_done(20);
        chk("lft_hs_count", 32'(job_hs), 4);
        if (dut_log.size() == 4) begin
            chk("lft_rows_t0", 32'(dut_log[0].rows), 5);
            chk("lft_cols_k0", 32'(dut_log[1].cols), 16);
            chk("lft_depth_n0", 32'(dut_log[0].depth), 16);
            chk("lft_depth_n1", 32'(dut_log[1].depth), 3);
            chk("lft_cols_k1", 32'(dut_log[3].cols), 7);
            chk("lft_rows_t3", 32'(dut_log[3].rows), 5);
        end else begin
            chk("lft_log_size", 32'(dut_log.size()), 4);
        end
        tick();

        // Backpressure with ready pattern 1,0,0,1
        tif.tile_ready_i = 1'b0;
        do_start(1, 2, 3, 0, 9, 0);
        begin
            logic [3:0] pat;
            int base;
            pat = 4'b1001;
            base = done_cnt;
            for (int i = 0; i < 200 && done_cnt == base; i++) begin
                tif.tile_ready_i = pat[3 - (i % 4)];
                tick();
            end
            chk("bp_done_seen", 32'(done_cnt - base), 1);
        end
        chk("bp_hs_count", 32'(job_hs), 6);
        chk("bp_stalled", 32'(stall_cnt > 0), 1);
        tif.tile_ready_i = 1'b1;
        tick();

        // Zero count job
        do_start(3, 0, 2, 0, 0, 0);
        wait_done(5);
        chk("zero_done_latency", 32'(done_cyc), 32'(start_cyc + 1));
        chk("zero_no_valid", 32'(valid_seen), 0);
        chk("zero_hs_count", 32'(job_hs), 0);
        tick();
        tick();

        // Clear after the 5th tile of a 12-tile job
        do_start(2, 2, 3, 0, 0, 0);
        begin
            int n;
            n = 0;
            while (job_hs < 5 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("clr_reached_5", 32'(job_hs), 5);
        end
        @(posedge clk); #1;
        clear = 1'b1;
        chk("clr_store_before", 32'(store_cnt), 1);
        begin
            int dbase;
            dbase = done_cnt;
            tick();
            clear = 1'b0;
            @(negedge clk);
            chk("clr_valid", 32'(tif.tile_valid_o), 0);
            chk("clr_busy", 32'(busy), 0);
            chk("clr_store_cnt", 32'(store_cnt), 0);
            chk("clr_done", 32'(done), 0);
            repeat (3) @(negedge clk);
            chk("clr_no_done_pulse", 32'(done_cnt - dbase), 0);
        end
        tick();
        do_start(2, 2, 3, 0, 0, 0);
        wait_done(40);
        chk("clr_rerun_hs", 32'(job_hs), 12);
        if (dut_log.size() > 0) begin
            chk("clr_rerun_m0", 32'(dut_log[0].m), 0);
            chk("clr_rerun_n0", 32'(dut_log[0].n), 0);
        end
        chk("clr_rerun_store", 32'(store_cnt), 4);
        tick();

        // start mid-job is ignored
        do_start(2, 2, 3, 0, 0, 0);
        tick();
        tick();
        do_start(1, 1, 1, 5, 5, 5);
        wait_done(40);
        chk("mid_hs_count", 32'(job_hs), 12);
        chk("mid_store", 32'(store_cnt), 4);
        tick();
        tick();
        chk("mid_idle_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/redmule_tile_sequencer.md
# redmule_tile_sequencer

Tile-iteration sequencer directly downstream of the RedMulE tiler. On the tiler's configuration-valid pulse it latches the iteration counts and leftovers, then walks the three GEMM tile loops: M rows outer, K columns middle, N reduction inner. For each tile it emits one command over a valid/ready handshake to the streamer/scheduler, carrying:
- tile coordinates;
- effective tile sizes, with leftovers applied on the last index of each dimension;
- accumulate-start and store-trigger flags.

## Interface
Parameters:
- ARRAY_WIDTH, 12, rows per full M tile.
- TILE, 16, columns per full K tile and elements per full N tile (ARRAY_HEIGHT*(PIPE_REGS+1)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear; returns block to IDLE.
- start_i  in  1  one-cycle pulse: tiler configuration valid.
- x_rows_iter_i  in  16  M tile count.
- w_cols_iter_i  in  16  K tile count.
- x_cols_iter_i  in  16  N tile count.
- x_rows_lftovr_i  in  8  rows in last M tile; 0 = full.
- w_cols_lftovr_i  in  8  cols in last K tile; 0 = full.
- x_cols_lftovr_i  in  8  elements in last N tile; 0 = full.
- tile_valid_o  out  1  command valid.
- tile_ready_i  in  1  consumer accepts.
- tile_m_o / tile_k_o / tile_n_o  out  16 each  tile indices.
- tile_rows_o / tile_cols_o / tile_depth_o  out  8 each  effective M/K/N sizes.
- first_n_o  out  1  tile_n_o==0; start a new accumulation.
- last_n_o  out  1  tile_n_o==last; store after this tile.
- last_o  out  1  final tile of the job.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job-complete pulse.
- store_cnt_o  out  16  count of store-triggering tiles accepted in the current job.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start_i:
  - Latch all *_iter_i and *_lftovr_i inputs.
  - Clear all indices and store_cnt_o.
- IDLE → DONE on start_i if any latched iter count is 0. No tile is emitted.
- RUN: tile_valid_o=1. Payload is registered and held stable until the handshake (tile_valid_o & tile_ready_i).
- On handshake, advance the counters:
  - n increments.
  - n wraps to 0 at x_cols_iter-1, which increments k.
  - k wraps at w_cols_iter-1, which increments m.
- On a handshake with last_n_o=1, store_cnt_o increments.
- RUN → DONE on handshake with last_o=1.
- DONE → IDLE unconditionally after one cycle; done_o=1 only in DONE.
- Effective sizes:
  - tile_rows_o = x_rows_lftovr if m==x_rows_iter-1 and x_rows_lftovr!=0, else ARRAY_WIDTH.
  - tile_cols_o and tile_depth_o follow the same rule with TILE.
- last_o = (m==x_rows_iter-1) & (k==w_cols_iter-1) & last_n_o.
- busy_o=1 in RUN and DONE.
- start_i while not IDLE is ignored; latched values are unchanged.
- clear_i has priority over start_i and over the handshake:
  - Next state IDLE; indices, store_cnt_o and the latched config are zeroed.
  - No done_o pulse is produced.
- Index and count arithmetic is unsigned 16-bit. With iter counts ≤ 0xFFFF no wrap-around beyond the programmed bound occurs.

## Timing
- Reset values: all outputs 0; state IDLE.
- start_i at cycle t → tile_valid_o=1 at t+1 with indices (0,0,0), first_n_o=1.
- Zero-count job: start_i at cycle t → done_o=1 at t+1; tile_valid_o stays 0.
- Throughput of one tile per cycle under continuous tile_ready_i=1.
- Handshake at cycle c presents the next tile at c+1.
- Final handshake at cycle c: tile_valid_o=0 and done_o=1 at c+1; busy_o=0 at c+2.
- tile_ready_i with tile_valid_o=0 has no effect.
- Payload is registered and never combinationally dependent on tile_ready_i.

## Test plan
- Basic loop order: iters M=2, K=2, N=3, no leftovers, ready tied 1.
  - Required: 12 tiles in 12 consecutive cycles, ordered (m,k,n) = (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2).
  - last_n_o on every third tile; store_cnt_o=4 at done_o; done_o exactly one cycle after the 12th handshake.
- Leftovers: M=1, K=2, N=2, lftovr rows=5, cols=7, depth=3.
  - Required: tile_rows_o=5 on all tiles.
  - tile_cols_o=16 for k=0 and 7 for k=1.
  - tile_depth_o=16 for n=0 and 3 for n=1.
- Backpressure: ready driven 1,0,0,1 pattern.
  - Required: payload stable while stalled; no tile skipped or duplicated.
- Zero count: K=0, start pulse → done_o at t+1; no tile_valid_o.
- clear_i asserted after the 5th tile of a 12-tile job.
  - Required: next cycle tile_valid_o=0, busy_o=0, store_cnt_o=0, no done_o.
  - A new start_i runs a full job from (0,0,0).
- start_i pulse mid-job with different counts → ignored; original job completes with original counts.
